// File: rtl/out_stream_ctrl_if.sv
// Handshake bundle between out_stream_ctrl, its upstream output FIFO and the host byte port.
// master: the controller side; slave: the FIFO/host environment side.
interface out_stream_ctrl_if;
  logic       START_DRAIN;
  logic [7:0] FRAME_LEN;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_DATA;
  logic       FIFO_RD_EN;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX_LAST;
  logic       BUSY;
  logic       DONE;
  logic       ERR_UNDERFLOW;

  modport master (
    input  START_DRAIN, FRAME_LEN, FIFO_EMPTY, FIFO_DATA, TX_READY,
    output FIFO_RD_EN, TX_DATA, TX_VALID, TX_LAST, BUSY, DONE, ERR_UNDERFLOW
  );

  modport slave (
    output START_DRAIN, FRAME_LEN, FIFO_EMPTY, FIFO_DATA, TX_READY,
    input  FIFO_RD_EN, TX_DATA, TX_VALID, TX_LAST, BUSY, DONE, ERR_UNDERFLOW
  );
endinterface

// File: rtl/out_stream_ctrl.sv
// out_stream_ctrl: drains FRAME_LEN bytes from an output FIFO onto a valid/ready host port.
// Define OUT_STREAM_CHECKSUM_EN to append an XOR checksum byte after the payload.
module out_stream_ctrl (
  input  logic              CLKEXT,
  input  logic              RST_GLO,
  out_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
`ifdef OUT_STREAM_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FINISH
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_len, w_len_nxt;
  logic [7:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0] r_stall_cnt, w_stall_cnt_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_tx_valid, w_tx_valid_nxt;
  logic       r_tx_last, w_tx_last_nxt;
  logic       r_err, w_err_nxt;
`ifdef OUT_STREAM_CHECKSUM_EN
  logic [7:0] r_csum, w_csum_nxt;
`endif

  logic [7:0] w_cnt_inc;
  logic [7:0] w_stall_inc;
  logic       w_hs;
  logic       w_fifo_rd_en;

  assign w_cnt_inc   = r_byte_cnt + 8'd1;
  assign w_stall_inc = r_stall_cnt + 8'd1;
  assign w_hs        = r_tx_valid && bus.TX_READY;

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_err       <= 1'b0;
`ifdef OUT_STREAM_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_last   <= w_tx_last_nxt;
      r_err       <= w_err_nxt;
`ifdef OUT_STREAM_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_stall_cnt_nxt = r_stall_cnt;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_last_nxt   = r_tx_last;
    w_err_nxt       = r_err;
    w_fifo_rd_en    = 1'b0;
`ifdef OUT_STREAM_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.START_DRAIN) begin
          w_err_nxt = 1'b0;
          if (bus.FRAME_LEN != 8'd0) begin
            w_len_nxt       = bus.FRAME_LEN;
            w_byte_cnt_nxt  = '0;
            w_stall_cnt_nxt = '0;
`ifdef OUT_STREAM_CHECKSUM_EN
            w_csum_nxt      = '0;
`endif
            w_state_nxt     = ST_FETCH;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end

      ST_FETCH: begin
        if (!bus.FIFO_EMPTY) begin
          w_fifo_rd_en = 1'b1;
          w_state_nxt  = ST_WAIT;
        end else begin
          w_stall_cnt_nxt = w_stall_inc;
          if (w_stall_inc == 8'hFF) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_FINISH;
          end
        end
      end

      ST_WAIT: begin
        w_tx_data_nxt  = bus.FIFO_DATA;
        w_tx_valid_nxt = 1'b1;
`ifdef OUT_STREAM_CHECKSUM_EN
        w_tx_last_nxt  = 1'b0;
`else
        w_tx_last_nxt  = (w_cnt_inc == r_len);
`endif
        w_state_nxt    = ST_SEND;
      end

      ST_SEND: begin
        if (w_hs) begin
          w_byte_cnt_nxt = w_cnt_inc;
          w_tx_valid_nxt = 1'b0;
          w_tx_last_nxt  = 1'b0;
          if (w_cnt_inc == r_len) begin
`ifdef OUT_STREAM_CHECKSUM_EN
            // Checksum byte is loaded on the same edge so CSUM presents it immediately.
            w_csum_nxt     = r_csum ^ r_tx_data;
            w_tx_data_nxt  = r_csum ^ r_tx_data;
            w_tx_valid_nxt = 1'b1;
            w_tx_last_nxt  = 1'b1;
            w_state_nxt    = ST_CSUM;
`else
            w_state_nxt    = ST_FINISH;
`endif
          end else begin
`ifdef OUT_STREAM_CHECKSUM_EN
            w_csum_nxt      = r_csum ^ r_tx_data;
`endif
            w_stall_cnt_nxt = '0;
            w_state_nxt     = ST_FETCH;
          end
        end
      end

`ifdef OUT_STREAM_CHECKSUM_EN
      ST_CSUM: begin
        if (w_hs) begin
          w_tx_valid_nxt = 1'b0;
          w_tx_last_nxt  = 1'b0;
          w_state_nxt    = ST_FINISH;
        end
      end
`endif

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A read strobe during reset would pop a byte that the aborted frame never consumes.
  assign bus.FIFO_RD_EN    = w_fifo_rd_en && !RST_GLO;
  assign bus.TX_DATA       = r_tx_data;
  assign bus.TX_VALID      = r_tx_valid;
  assign bus.TX_LAST       = r_tx_last;
  assign bus.BUSY          = (r_state != ST_IDLE);
  assign bus.DONE          = (r_state == ST_FINISH);
  assign bus.ERR_UNDERFLOW = r_err;

endmodule

// File: tb/tb_out_stream_ctrl.sv
// Self-checking bench for out_stream_ctrl: byte-stream model plus directed timing checks.
module tb_out_stream_ctrl;

`ifdef OUT_STREAM_CHECKSUM_EN
  localparam int unsigned CSUM_ON = 1;
`else
  localparam int unsigned CSUM_ON = 0;
`endif

  logic CLKEXT = 1'b0;
  logic RST_GLO;

  out_stream_ctrl_if bus ();

  out_stream_ctrl dut (
    .CLKEXT  (CLKEXT),
    .RST_GLO (RST_GLO),
    .bus     (bus)
  );

  always #5 CLKEXT = ~CLKEXT;

  int unsigned cyc = 0;
  always @(posedge CLKEXT) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_log[$];
  int unsigned hs_cyc[$];
  logic [7:0]  cs_acc = '0;

  bit          exp_busy = 0, exp_err = 0, exp_done_next = 0;
  bit          check_zero = 0, prev_stall = 0, prev_rd = 0, done_seen = 0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;
  int unsigned starve = 0, stall_cnt = 0, rd_cnt = 0, valid_cnt = 0;
  int unsigned hs_cnt = 0, done_cyc = 0, start_cyc = 0;

  bit          rand_mode = 0, gate = 1;
  int unsigned off_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: the model tracks frame activity, the expected byte stream and starvation.
  always @(negedge CLKEXT) begin
    if (RST_GLO) begin
      exp_busy = 0; exp_err = 0; exp_done_next = 0; starve = 0;
      prev_stall = 0; prev_rd = 0; check_zero = 1;
      exp_q.delete();
    end else begin
      if (check_zero) begin
        chk("rst_tx_data", bus.TX_DATA, 0);
        chk("rst_flags", {bus.TX_VALID, bus.TX_LAST, bus.FIFO_RD_EN, bus.BUSY, bus.DONE,
                          bus.ERR_UNDERFLOW}, 0);
        check_zero = 0;
      end
      chk("busy", bus.BUSY, exp_busy);
      chk("err", bus.ERR_UNDERFLOW, exp_err);
      chk("rd_legal", !(bus.FIFO_RD_EN && (bus.FIFO_EMPTY || !exp_busy || bus.TX_VALID)), 1);
      if (prev_stall) begin
        chk("hold_valid", bus.TX_VALID, 1);
        chk("hold_data", bus.TX_DATA, prev_data);
        chk("hold_last", bus.TX_LAST, prev_last);
      end
      if (exp_done_next) chk("uf_done", bus.DONE, 1);
      if (bus.TX_VALID && bus.TX_READY) begin
        hs_cyc.push_back(cyc);
        tx_log.push_back(bus.TX_DATA);
        hs_cnt++;
        chk("tx_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("tx_data", bus.TX_DATA, exp_q[0]);
          chk("tx_last", bus.TX_LAST, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
      end
      if (bus.TX_VALID && !bus.TX_READY) stall_cnt++;
      if (bus.TX_VALID) valid_cnt++;
      if (bus.FIFO_RD_EN) rd_cnt++;
      if (bus.DONE) begin
        chk("done_busy", bus.BUSY, 1);
        if (exp_done_next) exp_q.delete();
        else chk("done_all_sent", exp_q.size(), 0);
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (exp_busy && !bus.TX_VALID && !bus.DONE && !prev_rd) begin
        if (bus.FIFO_EMPTY) starve++;
        else starve = 0;
      end
      prev_stall = bus.TX_VALID && !bus.TX_READY;
      prev_data  = bus.TX_DATA;
      prev_last  = bus.TX_LAST;
      prev_rd    = bus.FIFO_RD_EN;
      if (bus.DONE) begin
        exp_busy = 0; exp_done_next = 0;
      end else if (!exp_busy && bus.START_DRAIN) begin
        exp_busy = 1; exp_err = 0; starve = 0;
      end
      if (starve == 255) begin
        exp_err = 1; exp_done_next = 1; starve = 0;
      end
    end
  end

  task automatic tick();
    logic rd;
    @(negedge CLKEXT);
    rd = bus.FIFO_RD_EN;
    @(posedge CLKEXT);
    #1;
    if (rd && fifo_q.size() != 0) bus.FIFO_DATA = fifo_q.pop_front();
    else bus.FIFO_DATA = 8'($urandom);
    bus.START_DRAIN = 1'b0;
    if (rand_mode) begin
      if (off_run >= 20 || $urandom_range(0, 3) != 0) begin
        gate = 1; off_run = 0;
      end else begin
        gate = 0; off_run++;
      end
      bus.TX_READY = ($urandom_range(0, 9) < 7);
      if (exp_busy && $urandom_range(0, 15) == 0) begin
        bus.START_DRAIN = 1'b1;
        bus.FRAME_LEN   = 8'($urandom);
      end
    end
    bus.FIFO_EMPTY = (fifo_q.size() == 0) || !gate;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    cs_acc ^= b;
  endtask

  task automatic load_frame(input int unsigned len);
    for (int unsigned i = 0; i < len; i++) push_byte(8'($urandom));
    if (CSUM_ON != 0 && len != 0) exp_q.push_back(cs_acc);
    cs_acc = '0;
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    while (exp_busy && n < bound) begin tick(); n++; end
    if (exp_busy) chk("idle_timeout", bus.BUSY, 0);
  endtask

  task automatic start_frame(input int unsigned len);
    bus.FRAME_LEN   = 8'(len);
    bus.START_DRAIN = 1'b1;
    bus.FIFO_EMPTY  = (fifo_q.size() == 0) || !gate;
    start_cyc = cyc;
    done_seen = 0;
    hs_cyc.delete();
    tx_log.delete();
    tick();
  endtask

  task automatic wait_done(input int unsigned bound);
    int unsigned n = 0;
    while (!done_seen && n < bound) begin tick(); n++; end
    chk("done_seen", done_seen, 1);
  endtask

  int unsigned n, s0, r0, v0, h0;

  initial begin
    RST_GLO = 1'b1;
    bus.START_DRAIN = 1'b0; bus.FRAME_LEN = '0; bus.FIFO_EMPTY = 1'b1;
    bus.FIFO_DATA = '0; bus.TX_READY = 1'b0;
    repeat (3) tick();
    RST_GLO = 1'b0;
    repeat (2) tick();

    // Three known bytes, host always ready: 3-cycle spacing and DONE right after.
    bus.TX_READY = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    if (CSUM_ON != 0) exp_q.push_back(cs_acc);
    cs_acc = '0;
    start_frame(3);
    wait_done(40);
    chk("t1_nbytes", tx_log.size(), 3 + CSUM_ON);
    if (tx_log.size() >= 3) begin
      chk("t1_b0", tx_log[0], 8'h11);
      chk("t1_b1", tx_log[1], 8'h22);
      chk("t1_blast", tx_log[tx_log.size() - 1], (CSUM_ON != 0) ? 8'h00 : 8'h33);
      chk("t1_hs0", hs_cyc[0] - start_cyc, 3);
      chk("t1_gap1", hs_cyc[1] - hs_cyc[0], 3);
      chk("t1_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end
    chk("t1_done", done_cyc - start_cyc, 10 + CSUM_ON);
    tick();

    // Host stalls for 10 cycles mid-frame.
    load_frame(5);
    start_frame(5);
    h0 = hs_cnt; n = 0;
    while (hs_cnt == h0 && n < 20) begin tick(); n++; end
    bus.TX_READY = 1'b0;
    n = 0;
    while (!bus.TX_VALID && n < 20) begin tick(); n++; end
    chk("t2_valid_up", bus.TX_VALID, 1);
    s0 = stall_cnt; r0 = rd_cnt;
    repeat (10) tick();
    chk("t2_stall_cycles", stall_cnt - s0, 10);
    chk("t2_no_extra_rd", rd_cnt - r0, 0);
    bus.TX_READY = 1'b1;
    wait_done(60);
    tick();

    // FIFO starved for the whole frame.
    r0 = rd_cnt;
    start_frame(4);
    wait_done(400);
    chk("t3_uf_cycles", done_cyc - start_cyc, 256);
    chk("t3_uf_err", bus.ERR_UNDERFLOW, 1);
    chk("t3_no_rd", rd_cnt - r0, 0);
    repeat (3) tick();

    // Zero-length frame clears the sticky error and reads nothing.
    r0 = rd_cnt; v0 = valid_cnt;
    start_frame(0);
    wait_done(2);
    chk("t4_done", done_cyc - start_cyc, 1);
    chk("t4_err_clear", bus.ERR_UNDERFLOW, 0);
    chk("t4_no_rd", rd_cnt - r0, 0);
    chk("t4_no_valid", valid_cnt - v0, 0);
    tick();

    // Reset while a byte is presented, then a clean frame.
    bus.TX_READY = 1'b0;
    load_frame(3);
    start_frame(3);
    n = 0;
    while (!bus.TX_VALID && n < 20) begin tick(); n++; end
    chk("t5_in_send", bus.TX_VALID, 1);
    RST_GLO = 1'b1;
    tick();
    RST_GLO = 1'b0;
    fifo_q.delete();
    cs_acc = '0;
    chk("t5_valid", bus.TX_VALID, 0);
    chk("t5_busy", bus.BUSY, 0);
    chk("t5_data", bus.TX_DATA, 0);
    tick();
    bus.TX_READY = 1'b1;
    load_frame(3);
    start_frame(3);
    wait_done(40);
    chk("t5_clean_bytes", tx_log.size(), 3 + CSUM_ON);
    tick();

    // Randomized frames with host back-pressure, FIFO gaps and ignored START_DRAIN pulses.
    rand_mode = 1;
    for (int unsigned f = 0; f < 24; f++) begin
      int unsigned len;
      wait_idle(5000);
      len = (f == 11) ? 255 : (f % 7 == 3) ? 0 : $urandom_range(1, 24);
      load_frame(len);
      start_frame(len);
    end
    wait_idle(5000);
    rand_mode = 0; gate = 1; bus.TX_READY = 1'b1;
    repeat (3) tick();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_fifo_empty", fifo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/out_stream_ctrl.md
OUT_STREAM_CTRL -- requirements
Module: out_stream_ctrl

Interface
REQ-001 The block SHALL use one clock, CLKEXT, and one reset, RST_GLO, which is synchronous and active-high.
REQ-002 Port CLKEXT  in  1  rising-edge system clock.
REQ-003 Port RST_GLO  in  1  synchronous active-high global reset.
REQ-004 Port START_DRAIN  in  1  single-cycle request to drain one frame.
REQ-005 Port FRAME_LEN  in  8  number of payload bytes in the frame; sampled on an accepted START_DRAIN.
REQ-006 Port FIFO_EMPTY  in  1  empty flag of the upstream output FIFO.
REQ-007 Port FIFO_DATA  in  8  FIFO read data; valid the cycle after a FIFO_RD_EN pulse.
REQ-008 Port FIFO_RD_EN  out  1  FIFO read strobe; single-cycle pulse.
REQ-009 Port TX_DATA  out  8  host byte.
REQ-010 Port TX_VALID  out  1  TX_DATA valid.
REQ-011 Port TX_READY  in  1  host accepts the byte.
REQ-012 Port TX_LAST  out  1  marks the final byte of the frame.
REQ-013 Port BUSY  out  1  high in every state except IDLE.
REQ-014 Port DONE  out  1  one-cycle end-of-frame pulse.
REQ-015 Port ERR_UNDERFLOW  out  1  sticky FIFO-starvation error flag.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, WAIT, SEND, CSUM and FINISH.
REQ-017 In IDLE, START_DRAIN=1 with FRAME_LEN≠0 SHALL latch FRAME_LEN, clear the byte counter and the stall counter, and move to FETCH.
REQ-018 In IDLE, START_DRAIN=1 with FRAME_LEN=0 SHALL move to FINISH without any FIFO read.
REQ-019 START_DRAIN SHALL be ignored outside IDLE.
REQ-020 In FETCH with FIFO_EMPTY=0, the block SHALL pulse FIFO_RD_EN for one cycle and move to WAIT.
REQ-021 In FETCH with FIFO_EMPTY=1, the block SHALL increment an 8-bit stall counter; when the counter reaches 255, it SHALL set ERR_UNDERFLOW and move to FINISH.
REQ-022 In WAIT, the block SHALL register FIFO_DATA into TX_DATA, set TX_VALID, and move to SEND.
REQ-023 In SEND, TX_DATA, TX_VALID and TX_LAST SHALL hold stable until TX_VALID and TX_READY are both high on the same edge (handshake).
REQ-024 On a SEND handshake, the block SHALL increment the byte counter and clear TX_VALID, then:
- if the counter now equals the latched length, go to CSUM when CHECKSUM is compiled in, otherwise go to FINISH;
- otherwise, clear the stall counter and go to FETCH.
REQ-025 TX_LAST SHALL be high with the final payload byte when checksum is compiled out, and with the checksum byte when it is compiled in.
REQ-026 Minimum throughput SHALL be 1 byte per 3 cycles (FETCH, WAIT, SEND); TX_READY held high SHALL cause no further stall.
REQ-027 FINISH SHALL assert DONE for one cycle and return to IDLE.
REQ-028 ERR_UNDERFLOW SHALL clear only on reset or on the next accepted START_DRAIN.
REQ-029 FIFO_RD_EN SHALL never be asserted while FIFO_EMPTY=1, and never outside FETCH.
REQ-030 The byte counter SHALL be 8 bits wide; FRAME_LEN=255 SHALL be drained fully, with no wrap-around before the length compare.

Reset
REQ-031 RST_GLO=1 at a rising edge SHALL force state IDLE and drive TX_DATA=0, TX_VALID=0, TX_LAST=0, FIFO_RD_EN=0, BUSY=0, DONE=0, ERR_UNDERFLOW=0, with all counters and the checksum cleared.
REQ-032 A reset during any state SHALL abort the frame with no pending FIFO read and no DONE pulse.
REQ-033 Reset SHALL take priority over every simultaneous event, including handshake and START_DRAIN.

Configuration
REQ-034 Macro OUT_STREAM_CHECKSUM_EN, when defined, SHALL accumulate the XOR of all payload bytes sent and transmit it in CSUM as one extra byte.
- The checksum byte SHALL be sent with TX_VALID=1 and TX_LAST=1, under the same handshake rules, then the FSM moves to FINISH.
- With FRAME_LEN=0, no checksum byte SHALL be sent.
REQ-035 When OUT_STREAM_CHECKSUM_EN is undefined, the CSUM state and the XOR register SHALL be absent, and frames SHALL carry exactly FRAME_LEN bytes.

Verification
REQ-036 FIFO preloaded with 0x11,0x22,0x33, FRAME_LEN=3, TX_READY=1 -> TX bytes 11,22,33 at 3-cycle spacing, TX_LAST on 0x33 (or on checksum 0x00 when enabled), DONE 1 cycle after.
REQ-037 TX_READY held low for 10 cycles mid-frame -> TX_DATA/TX_VALID stable for all 10 cycles, no extra FIFO_RD_EN, no lost or duplicated byte.
REQ-038 FIFO_EMPTY held high after START_DRAIN with FRAME_LEN=4 -> ERR_UNDERFLOW=1 after 255 stall cycles, DONE pulse, FIFO_RD_EN never asserted.
REQ-039 START_DRAIN with FRAME_LEN=0 -> DONE within 2 cycles, TX_VALID and FIFO_RD_EN stay 0.
REQ-040 RST_GLO asserted in SEND with TX_VALID=1 -> all outputs 0 on the next edge; a new START_DRAIN then completes a clean frame.
